peri_timer: RTL and testbench

PERI_TIMER -- requirements
Module: peri_timer

---
 rtl/peri_timer.sv | 153 +++++++++++++++
 tb/tb_peri_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/peri_timer.sv
// Peribus timer: 8-bit prescaler feeding a 16-bit down-counter with reload, one-shot mode and W1C status.
// Latency: register writes land on the next rising edge; read_data is registered, one cycle after read_enable.
// Backpressure: none; every write strobe is accepted and reads have no side effects.
module peri_timer #(
  parameter logic [15:0] RELOAD_RST = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  addr,
  input  logic [15:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [15:0] read_data,
  output logic        irq
);

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PSC    = 3'd1;
  localparam logic [2:0] ADDR_RELOAD = 3'd2;
  localparam logic [2:0] ADDR_COUNT  = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // Architectural state
  logic        en;
  logic        oneshot;
  logic        irq_en;
  logic [7:0]  psc;
  logic [15:0] reload;
  logic [15:0] count;
  logic        tf;
  logic        ovr;
  logic [7:0]  prescaler;

  // Write decode
  logic wr_ctrl;
  logic wr_psc;
  logic wr_reload;
  logic wr_count;
  logic wr_status;

  assign wr_ctrl   = write_enable && (addr == ADDR_CTRL);
  assign wr_psc    = write_enable && (addr == ADDR_PSC);
  assign wr_reload = write_enable && (addr == ADDR_RELOAD);
  assign wr_count  = write_enable && (addr == ADDR_COUNT);
  assign wr_status = write_enable && (addr == ADDR_STATUS);

  // Timer events. The >= compare keeps the prescaler from running past a
  // PSC value that was lowered while counting.
  logic tick;
  logic count_zero;
  logic terminal;
  logic en_rise;

  assign tick       = en && (prescaler >= psc);
  assign count_zero = (count == 16'd0);
  // A COUNT write discards a coincident tick, so it cannot become a terminal event.
  assign terminal   = tick && count_zero && !wr_count;
  assign en_rise    = wr_ctrl && !en && write_data[0];

  // Prescaler: restarts on enable or COUNT write, wraps at PSC, holds while stopped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prescaler <= 8'd0;
    end else if (wr_count || en_rise) begin
      prescaler <= 8'd0;
    end else if (en) begin
      prescaler <= tick ? 8'd0 : prescaler + 8'd1;
    end
  end

  // CTRL: a bus write overrides the one-shot auto-clear of EN.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      irq_en  <= 1'b0;
    end else if (wr_ctrl) begin
      en      <= write_data[0];
      oneshot <= write_data[1];
      irq_en  <= write_data[2];
    end else if (terminal && oneshot) begin
      en <= 1'b0;
    end
  end

  // PSC and RELOAD: plain storage; RELOAD is only consumed at the next terminal event.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      psc    <= 8'd0;
      reload <= RELOAD_RST;
    end else begin
      if (wr_psc) begin
        psc <= write_data[7:0];
      end
      if (wr_reload) begin
        reload <= write_data;
      end
    end
  end

  // COUNT: bus write wins over a tick; otherwise decrement or reload at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= 16'd0;
    end else if (wr_count) begin
      count <= write_data;
    end else if (tick) begin
      if (count_zero) begin
        count <= oneshot ? 16'd0 : reload;
      end else begin
        count <= count - 16'd1;
      end
    end
  end

  // STATUS: write-1-to-clear, with a coincident terminal event taking priority.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tf  <= 1'b0;
      ovr <= 1'b0;
    end else begin
      tf  <= (tf  & ~(wr_status & write_data[0])) | terminal;
      ovr <= (ovr & ~(wr_status & write_data[1])) | (terminal & tf);
    end
  end

  // Read mux over the current register contents; unmapped offsets read zero.
  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = 16'h0000;
    case (addr)
      ADDR_CTRL:   rd_mux = {13'd0, irq_en, oneshot, en};
      ADDR_PSC:    rd_mux = {8'd0, psc};
      ADDR_RELOAD: rd_mux = reload;
      ADDR_COUNT:  rd_mux = count;
      ADDR_STATUS: rd_mux = {14'd0, ovr, tf};
      default:     rd_mux = 16'h0000;
    endcase
  end

  // Registered read data, held while read_enable is low.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      read_data <= 16'h0000;
    end else if (read_enable) begin
      read_data <= rd_mux;
    end
  end

  assign irq = irq_en & (tf | ovr);

endmodule

// File: tb/tb_peri_timer.sv
// Directed bench for peri_timer: register decode, periodic and one-shot counting,
// W1C/overrun status, write/event collisions and mid-run reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_peri_timer;

  logic        clock;
  logic        reset_n;
  logic [2:0]  addr;
  logic [15:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [15:0] read_data;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rdv;

  peri_timer #(.RELOAD_RST(16'hFFFF)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .addr         (addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    @(negedge clock);
    write_enable = 1'b0;
  endtask

  // Called at a falling edge; read_data loads on the next rising edge.
  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    addr        = a;
    read_enable = 1'b1;
    @(negedge clock);
    read_enable = 1'b0;
    d = read_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] per_tab [0:16];
    logic [15:0] one_tab [0:3];
    per_tab = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0,
                16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd3};
    one_tab = '{16'd2, 16'd1, 16'd0, 16'd0};

    reset_n      = 1'b0;
    addr         = 3'd0;
    write_data   = 16'h0000;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reset state
    check("rst_rdata", read_data, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    rd(3'd0, rdv); check("rst_ctrl", rdv, 16'h0000);
    rd(3'd1, rdv); check("rst_psc", rdv, 16'h0000);
    rd(3'd2, rdv); check("rst_reload", rdv, 16'hFFFF);
    rd(3'd3, rdv); check("rst_count", rdv, 16'h0000);
    rd(3'd4, rdv); check("rst_status", rdv, 16'h0000);

    // Read data holds with read_enable low; read-after-write returns the new value
    wr(3'd2, 16'h1234);
    check("hold_rdata", read_data, 16'h0000);
    rd(3'd2, rdv); check("raw_reload", rdv, 16'h1234);

    // Decode: unmapped offsets, CTRL and PSC width masking
    wr(3'd5, 16'hFFFF);
    wr(3'd6, 16'hFFFF);
    wr(3'd7, 16'hFFFF);
    rd(3'd5, rdv); check("dec_off5", rdv, 16'h0000);
    rd(3'd6, rdv); check("dec_off6", rdv, 16'h0000);
    rd(3'd7, rdv); check("dec_off7", rdv, 16'h0000);
    // CTRL=7 with PSC=0, COUNT=0: one-shot terminal on the very next edge
    wr(3'd0, 16'hFFFF);
    rd(3'd0, rdv); check("dec_ctrl", rdv, 16'h0007);
    rd(3'd4, rdv); check("dec_os_status", rdv, 16'h0001);
    check("dec_os_irq", {15'd0, irq}, 16'h0001);
    rd(3'd0, rdv); check("dec_os_ctrl", rdv, 16'h0006);
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0003);
    rd(3'd4, rdv); check("dec_clr_status", rdv, 16'h0000);
    wr(3'd1, 16'hFFFF);
    rd(3'd1, rdv); check("dec_psc", rdv, 16'h00FF);

    // Periodic: PSC=1, RELOAD=3, COUNT=3, enable at E0, stream COUNT reads
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h0003);
    wr(3'd3, 16'h0003);
    wr(3'd0, 16'h0001);
    addr        = 3'd3;
    read_enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      check($sformatf("per_count_e%0d", k), read_data, per_tab[k]);
    end
    read_enable = 1'b0;
    // Two terminal events (E0+8, E0+16) without clearing: TF and OVR
    rd(3'd4, rdv); check("per_status", rdv, 16'h0003);
    // Stop with IRQ_EN set at E0+19; COUNT stays at 2
    wr(3'd0, 16'h0004);
    check("ovr_irq", {15'd0, irq}, 16'h0001);
    rd(3'd3, rdv); check("stop_count", rdv, 16'h0002);
    repeat (6) @(negedge clock);
    rd(3'd3, rdv); check("stop_hold", rdv, 16'h0002);

    // W1C per bit
    wr(3'd4, 16'h0001);
    rd(3'd4, rdv); check("w1c_tf", rdv, 16'h0002);
    check("w1c_irq_ovr", {15'd0, irq}, 16'h0001);
    wr(3'd4, 16'h0002);
    rd(3'd4, rdv); check("w1c_ovr", rdv, 16'h0000);
    check("w1c_irq_off", {15'd0, irq}, 16'h0000);

    // One-shot: PSC=0, RELOAD=2, COUNT=2, EN|ONESHOT|IRQ_EN
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0002);
    wr(3'd3, 16'h0002);
    wr(3'd0, 16'h0007);
    addr        = 3'd3;
    read_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("os_count_e%0d", k), read_data, one_tab[k]);
    end
    read_enable = 1'b0;
    repeat (20) @(negedge clock);
    rd(3'd3, rdv); check("os_count_idle", rdv, 16'h0000);
    rd(3'd0, rdv); check("os_ctrl", rdv, 16'h0006);
    rd(3'd4, rdv); check("os_status", rdv, 16'h0001);
    check("os_irq", {15'd0, irq}, 16'h0001);

    // Collision: W1C of TF on the same edge as a terminal event
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0003);
    wr(3'd2, 16'h0005);
    wr(3'd3, 16'h0000);
    wr(3'd0, 16'h0001);
    wr(3'd4, 16'h0001);
    wr(3'd0, 16'h0000);
    rd(3'd4, rdv); check("col_w1c_tf", rdv, 16'h0001);

    // Collision: COUNT write on the same edge as a tick
    wr(3'd4, 16'h0003);
    wr(3'd3, 16'h0008);
    wr(3'd0, 16'h0001);
    wr(3'd3, 16'h0010);
    rd(3'd3, rdv); check("col_count_wr", rdv, 16'h0010);
    wr(3'd0, 16'h0000);

    // Mid-run reset with a coincident CTRL write that must be ignored
    wr(3'd1, 16'h0002);
    wr(3'd2, 16'h0003);
    wr(3'd3, 16'h0003);
    wr(3'd0, 16'h0005);
    repeat (5) @(negedge clock);
    reset_n      = 1'b0;
    addr         = 3'd0;
    write_data   = 16'h0007;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    @(negedge clock);
    reset_n      = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check("mr_rdata", read_data, 16'h0000);
    check("mr_irq", {15'd0, irq}, 16'h0000);
    rd(3'd0, rdv); check("mr_ctrl", rdv, 16'h0000);
    rd(3'd1, rdv); check("mr_psc", rdv, 16'h0000);
    rd(3'd2, rdv); check("mr_reload", rdv, 16'hFFFF);
    rd(3'd3, rdv); check("mr_count", rdv, 16'h0000);
    rd(3'd4, rdv); check("mr_status", rdv, 16'h0000);
    repeat (10) @(negedge clock);
    rd(3'd3, rdv); check("mr_count_idle", rdv, 16'h0000);
    rd(3'd4, rdv); check("mr_status_idle", rdv, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
